// File: rtl/spi_frame_buffer_if.sv
// Signal bundle for spi_frame_buffer: the SPI pins plus the read-side
// bank access and frame status. The master modport is the side that
// drives SPI and reads frames; the slave modport is the buffer itself.
interface spi_frame_buffer_if #(
    parameter int BYTES_PER_SAMPLE = 1,
    parameter int DEPTH            = 64
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int SW     = 8 * BYTES_PER_SAMPLE;

    logic              SCK;
    logic              SSEL;
    logic              MOSI;
    logic              MISO;
    logic [ADDR_W-1:0] rd_addr;
    logic [SW-1:0]     rd_data;
    logic              frame_valid;
    logic              frame_ack;
    logic              overflow;
    logic [7:0]        frame_count;

    modport master (
        output SCK, SSEL, MOSI, rd_addr, frame_ack,
        input  MISO, rd_data, frame_valid, overflow, frame_count
    );

    modport slave (
        input  SCK, SSEL, MOSI, rd_addr, frame_ack,
        output MISO, rd_data, frame_valid, overflow, frame_count
    );
endinterface

// File: rtl/spi_frame_buffer.sv
// spi_frame_buffer: SPI mode-0 slave (MSB first) that assembles
// BYTES_PER_SAMPLE bytes into one sample and fills a ping-pong pair of
// DEPTH-sample banks. A full write bank is handed to the reader by
// swapping banks; if the reader still holds the previous frame the
// controller parks in HOLD and drops incoming samples (sticky overflow).
//
// Optional feature: define SFB_STATUS_MISO_EN to shift a status byte
// {frame_valid, overflow, state==HOLD, 5'b0} out on MISO at every byte.
// Without it MISO is tied low.
//
// State table:
//   FILL | samples are written into the write bank at wr_ptr
//   HOLD | write bank full, read bank still owned by reader; samples dropped
module spi_frame_buffer #(
    parameter int BYTES_PER_SAMPLE = 1,
    parameter int DEPTH            = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_frame_buffer_if.slave    bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int SW     = 8 * BYTES_PER_SAMPLE;
    localparam int BCW    = (BYTES_PER_SAMPLE > 1) ? $clog2(BYTES_PER_SAMPLE) : 1;

    localparam logic [BCW-1:0]    LAST_BYTE = BCW'(BYTES_PER_SAMPLE - 1);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    // [0] first sync flop, [1] synchronized value, [2] history
    logic [2:0] sck_s;
    logic [2:0] ssel_s;
    logic [2:0] mosi_s;

    logic sck_rise;
    logic ssel_idle;

    logic [2:0]     bit_cnt;
    logic [7:0]     byte_sr;
    logic [BCW-1:0] byte_cnt;
    logic [SW-1:0]  samp_sr;
    logic [SW-1:0]  samp_next;
    logic           samp_vld;
    logic [SW-1:0]  samp_data;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic              bank_sel, bank_sel_nxt;
    logic              frame_valid, frame_valid_nxt;
    logic              overflow, overflow_nxt;
    logic [7:0]        frame_count, frame_count_nxt;
    logic              wr_en;

    logic [SW-1:0] mem0 [DEPTH];
    logic [SW-1:0] mem1 [DEPTH];
    logic [SW-1:0] rd_q;
    logic          miso;

    // Bring the SPI pins into the clk domain; SSEL idles high out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_s  <= 3'b000;
            ssel_s <= 3'b111;
            mosi_s <= 3'b000;
        end else begin
            sck_s  <= {sck_s[1:0], bus.SCK};
            ssel_s <= {ssel_s[1:0], bus.SSEL};
            mosi_s <= {mosi_s[1:0], bus.MOSI};
        end
    end

    assign sck_rise = sck_s[1] & ~sck_s[2];
    // Select must be seen low on both the synchronized and history flop,
    // so any high blip (including the rising edge) counts as deselect.
    assign ssel_idle = ssel_s[1] | ssel_s[2];

    // MOSI is taken from the history flop: it lags by one cycle, keeping
    // the sampled bit well clear of any MOSI change around the SCK edge.
    assign samp_next = SW'({samp_sr, byte_sr[6:0], mosi_s[2]});

    // Bit/byte/sample assembly; deselect throws away any partial byte or sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            byte_sr   <= '0;
            byte_cnt  <= '0;
            samp_sr   <= '0;
            samp_vld  <= 1'b0;
            samp_data <= '0;
        end else begin
            samp_vld <= 1'b0;
            if (ssel_idle) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end else if (sck_rise) begin
                byte_sr <= {byte_sr[6:0], mosi_s[2]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    if (byte_cnt == LAST_BYTE) begin
                        samp_vld  <= 1'b1;
                        samp_data <= samp_next;
                        byte_cnt  <= '0;
                    end else begin
                        samp_sr  <= samp_next;
                        byte_cnt <= byte_cnt + BCW'(1);
                    end
                end
            end
        end
    end

    // Bank controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            wr_ptr      <= '0;
            bank_sel    <= 1'b0;
            frame_valid <= 1'b0;
            overflow    <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            state       <= state_nxt;
            wr_ptr      <= wr_ptr_nxt;
            bank_sel    <= bank_sel_nxt;
            frame_valid <= frame_valid_nxt;
            overflow    <= overflow_nxt;
            frame_count <= frame_count_nxt;
        end
    end

    // Bank controller next state: write, frame completion, swap and release.
    always_comb begin
        state_nxt       = state;
        wr_ptr_nxt      = wr_ptr;
        bank_sel_nxt    = bank_sel;
        frame_valid_nxt = frame_valid;
        overflow_nxt    = overflow;
        frame_count_nxt = frame_count;
        wr_en           = 1'b0;
        case (state)
            FILL: begin
                if (bus.frame_ack && frame_valid) begin
                    frame_valid_nxt = 1'b0;
                end
                if (samp_vld) begin
                    wr_en      = 1'b1;
                    wr_ptr_nxt = wr_ptr + ADDR_W'(1);
                    if (wr_ptr == LAST_PTR) begin
                        frame_count_nxt = frame_count + 8'd1;
                        // An ack landing on the completing write frees the
                        // read bank just in time, so swap straight away.
                        if (!frame_valid || bus.frame_ack) begin
                            bank_sel_nxt    = ~bank_sel;
                            frame_valid_nxt = 1'b1;
                        end else begin
                            state_nxt = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (samp_vld) begin
                    overflow_nxt = 1'b1;
                end
                if (bus.frame_ack) begin
                    bank_sel_nxt = ~bank_sel;
                    state_nxt    = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Bank 0 storage: written while bank 0 is the write bank.
    always_ff @(posedge clk) begin
        if (wr_en && !bank_sel) begin
            mem0[wr_ptr] <= samp_data;
        end
    end

    // Bank 1 storage: written while bank 1 is the write bank.
    always_ff @(posedge clk) begin
        if (wr_en && bank_sel) begin
            mem1[wr_ptr] <= samp_data;
        end
    end

    // Registered read from whichever bank is not being written.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= bank_sel ? mem0[bus.rd_addr] : mem1[bus.rd_addr];
        end
    end

`ifdef SFB_STATUS_MISO_EN
    logic       sck_fall;
    logic [7:0] miso_sr;
    logic [7:0] status_byte;

    assign sck_fall    = ~sck_s[1] & sck_s[2];
    assign status_byte = {frame_valid, overflow, (state == HOLD), 5'b0};

    // Status shifter: preloaded while deselected, reloaded on the falling
    // edge that ends each byte, otherwise advanced on every falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            miso_sr <= 8'd0;
        end else if (ssel_idle || (sck_fall && bit_cnt == 3'd0)) begin
            miso_sr <= status_byte;
        end else if (sck_fall) begin
            miso_sr <= {miso_sr[6:0], 1'b0};
        end
    end

    assign miso = ~ssel_idle & miso_sr[7];
`else
    assign miso = 1'b0;
`endif

    assign bus.MISO        = miso;
    assign bus.rd_data     = rd_q;
    assign bus.frame_valid = frame_valid;
    assign bus.overflow    = overflow;
    assign bus.frame_count = frame_count;
endmodule

// File: doc/spi_frame_buffer.md
SPI_FRAME_BUFFER -- requirements
Module: spi_frame_buffer

Interface
REQ-001 The block SHALL have parameter BYTES_PER_SAMPLE, default 1, SPI bytes per sample, legal range 1..4.
REQ-002 The block SHALL have parameter DEPTH, default 64, samples per frame, power of two, legal range 4..1024.
REQ-003 The block SHALL derive ADDR_W = log2(DEPTH) and SW = 8*BYTES_PER_SAMPLE.
REQ-004 The block SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 The block SHALL have port SCK, input, 1 bit, SPI clock, asynchronous to clk.
REQ-007 The block SHALL have port SSEL, input, 1 bit, SPI select, active-low.
REQ-008 The block SHALL have port MOSI, input, 1 bit, SPI data in.
REQ-009 The block SHALL have port MISO, output, 1 bit, SPI data out.
REQ-010 The block SHALL have port rd_addr, input, ADDR_W bits, read-bank sample index.
REQ-011 The block SHALL have port rd_data, output, SW bits, read-bank sample.
REQ-012 The block SHALL have port frame_valid, output, 1 bit, a complete frame is in the read bank.
REQ-013 The block SHALL have port frame_ack, input, 1 bit, one-cycle pulse releasing the read bank.
REQ-014 The block SHALL have port overflow, output, 1 bit, sticky flag: a sample was dropped.
REQ-015 The block SHALL have port frame_count, output, 8 bits, count of completed frames, wraps 255->0.

Function
REQ-016 SCK, SSEL and MOSI SHALL each pass a 2-flop synchronizer plus one history flop; SCK edges SHALL be detected on the synchronized signals.
REQ-017 SPI SHALL be mode 0, MSB first; MOSI SHALL be sampled on each synchronized SCK rising edge while synchronized SSEL is low.
REQ-018 On the 8th sampled bit, a byte SHALL complete; BYTES_PER_SAMPLE completed bytes SHALL form one sample, first byte in the MSBs.
REQ-019 A sample SHALL be written to the write bank at wr_ptr on the clk edge following completion of its last byte, and wr_ptr SHALL then increment.
REQ-020 SSEL rising mid-byte or mid-sample SHALL discard the partial byte and sample; wr_ptr SHALL be kept, so frames span SPI transactions.
REQ-021 Storage SHALL be two banks of DEPTH x SW (ping-pong): one write bank, one read bank.
REQ-022 The bank controller SHALL have states FILL and HOLD.
REQ-023 FILL: when the write at wr_ptr = DEPTH-1 occurs, wr_ptr SHALL wrap to 0 and frame_count SHALL increment; if frame_valid is 0, banks SHALL swap and frame_valid SHALL be 1 next cycle; otherwise the state SHALL go to HOLD.
REQ-024 HOLD: completed samples SHALL be dropped and overflow set; on frame_ack, banks SHALL swap, frame_valid SHALL stay 1 and the state SHALL return to FILL.
REQ-025 In FILL, frame_ack with frame_valid = 1 SHALL clear frame_valid next cycle; frame_ack with frame_valid = 0 SHALL be ignored.
REQ-026 Simultaneous frame_ack and frame completion in FILL SHALL swap banks with frame_valid remaining 1.
REQ-027 rd_data SHALL be registered: the value at read bank[rd_addr] SHALL appear one clk after rd_addr is presented.
REQ-028 overflow SHALL be cleared only by rst.

Reset
REQ-029 rst SHALL force state FILL, wr_ptr 0, bank select 0, byte and sample assembly cleared, frame_valid 0, overflow 0, frame_count 0, rd_data 0 and MISO 0.
REQ-030 Reset mid-transaction SHALL discard all partial data; bank contents SHALL NOT be cleared.

Configuration
REQ-031 With macro SFB_STATUS_MISO_EN defined, at each byte start the block SHALL load status byte {frame_valid, overflow, state==HOLD, 5'b0} and shift it MSB first on MISO, changing on synchronized SCK falling edges.
REQ-032 Without SFB_STATUS_MISO_EN, MISO SHALL be constant 0 and no status logic SHALL exist.
REQ-033 With SFB_STATUS_MISO_EN defined, MISO SHALL be 0 whenever synchronized SSEL is high.

Verification
REQ-034 DEPTH=4, BYTES_PER_SAMPLE=2, send bytes 12 34 56 78 9A BC DE F0 -> frame_valid=1, rd_addr 0..3 returns 1234, 5678, 9ABC, DEF0, frame_count=1.
REQ-035 Send 3 bits, raise SSEL, then send 4 full samples -> the partial bits are discarded and exactly those 4 samples are read back.
REQ-036 Two frames without frame_ack, then 1 more sample -> state HOLD, overflow=1, the sample is dropped; frame_ack -> frame 2 readable, frame_valid stays 1.
REQ-037 frame_ack pulsed on the same cycle as the last sample write of frame 2 -> banks swap, frame_valid stays 1, overflow stays 0.
REQ-038 rst asserted after 2 samples, then 4 new samples sent -> only the 4 new samples are in the frame, frame_count=1.
REQ-039 With SFB_STATUS_MISO_EN defined, frame_valid=1 and overflow=0 -> MISO shifts 0x80 during the next byte.
